// File: rtl/password_programmer.sv
// password_programmer: four-digit password entry and commit FSM with a
// seven-segment status display.
// Optional feature: define PASSWORD_CONFIRM_EN to require the code to be
// entered twice (a CONFIRM pass) before it is committed.
module password_programmer #(
  parameter logic [15:0] DEFAULT_PWD = 16'h4321
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next,
  input  logic [3:0]  digit_in,
  output logic [15:0] pwd_out,
  output logic        pwd_update,
  output logic        busy,
  output logic [0:6]  fsm_out_0,
  output logic [0:6]  fsm_out_1,
  output logic [0:6]  fsm_out_2,
  output logic [0:6]  fsm_out_3
);

  // Active-low segment patterns, bit 0 = seg a ... bit 6 = seg g.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_C     = 7'b0110001;
  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_O     = 7'b1100010;
  localparam logic [0:6] SEG_N     = 7'b1101010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_R     = 7'b1111010;

`ifdef PASSWORD_CONFIRM_EN
  typedef enum logic [2:0] {IDLE, ENTRY, CONFIRM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, ENTRY, DONE, ERR} state_t;
`endif

  state_t      state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic [3:0]  stage_reg [4];
  logic [3:0]  stage_next [4];
  logic        btn_reg;
  logic [15:0] pwd_reg;
  logic        pwd_update_reg;
  logic        commit;
  logic        next_pulse;
  logic        digit_ok;
  logic [0:6]  entry_seg [4];
  logic [0:6]  disp [4];

  assign next_pulse = next & ~btn_reg;
  assign digit_ok   = (digit_in <= 4'd9);

  // State, index, staging, committed password and update pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      btn_reg        <= 1'b0;
      pwd_reg        <= DEFAULT_PWD;
      pwd_update_reg <= 1'b0;
      for (int i = 0; i < 4; i++) stage_reg[i] <= 4'd0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      btn_reg        <= next;
      pwd_update_reg <= commit;
      for (int i = 0; i < 4; i++) stage_reg[i] <= stage_next[i];
      // The fourth digit is taken straight from digit_in: on the committing
      // event it either is being captured now or equals the staged copy.
      if (commit) pwd_reg <= {digit_in, stage_reg[2], stage_reg[1], stage_reg[0]};
    end
  end

  // Next-state logic: capture, confirm, commit and error handling.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    commit     = 1'b0;
    for (int i = 0; i < 4; i++) stage_next[i] = stage_reg[i];

    if (next_pulse) begin
      case (state_reg)
        IDLE: begin
          if (!digit_ok) begin
            state_next = ERR;
            idx_next   = 2'd0;
            for (int i = 0; i < 4; i++) stage_next[i] = 4'd0;
          end else begin
            stage_next[0] = digit_in;
            state_next    = ENTRY;
            idx_next      = 2'd1;
          end
        end
        ENTRY: begin
          if (!digit_ok) begin
            state_next = ERR;
            idx_next   = 2'd0;
            for (int i = 0; i < 4; i++) stage_next[i] = 4'd0;
          end else begin
            stage_next[idx_reg] = digit_in;
            if (idx_reg == 2'd3) begin
`ifdef PASSWORD_CONFIRM_EN
              state_next = CONFIRM;
              idx_next   = 2'd0;
`else
              state_next = DONE;
              idx_next   = 2'd0;
              commit     = 1'b1;
`endif
            end else begin
              idx_next = idx_reg + 2'd1;
            end
          end
        end
`ifdef PASSWORD_CONFIRM_EN
        CONFIRM: begin
          if (!digit_ok || digit_in != stage_reg[idx_reg]) begin
            state_next = ERR;
            idx_next   = 2'd0;
            for (int i = 0; i < 4; i++) stage_next[i] = 4'd0;
          end else if (idx_reg == 2'd3) begin
            state_next = DONE;
            idx_next   = 2'd0;
            commit     = 1'b1;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
`endif
        DONE, ERR: begin
          state_next = IDLE;
          idx_next   = 2'd0;
          for (int i = 0; i < 4; i++) stage_next[i] = 4'd0;
        end
        default: begin
          state_next = IDLE;
          idx_next   = 2'd0;
        end
      endcase
    end
  end

  // Digit position gi shows a dash once digit gi has been entered/confirmed.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dash
      assign entry_seg[gi] = (2'(gi) < idx_reg) ? SEG_DASH : SEG_BLANK;
    end
  endgenerate

  // Display decode from state and index.
  always_comb begin
    for (int i = 0; i < 4; i++) disp[i] = SEG_BLANK;
    case (state_reg)
      ENTRY: begin
        for (int i = 0; i < 4; i++) disp[i] = entry_seg[i];
      end
`ifdef PASSWORD_CONFIRM_EN
      CONFIRM: begin
        for (int i = 0; i < 3; i++) disp[i] = entry_seg[i];
        disp[3] = SEG_C;
      end
`endif
      DONE: begin
        disp[3] = SEG_D;
        disp[2] = SEG_O;
        disp[1] = SEG_N;
        disp[0] = SEG_E;
      end
      ERR: begin
        disp[3] = SEG_BLANK;
        disp[2] = SEG_E;
        disp[1] = SEG_R;
        disp[0] = SEG_R;
      end
      default: ;
    endcase
  end

`ifdef PASSWORD_CONFIRM_EN
  assign busy = (state_reg == ENTRY) || (state_reg == CONFIRM);
`else
  assign busy = (state_reg == ENTRY);
`endif

  assign pwd_out    = pwd_reg;
  assign pwd_update = pwd_update_reg;
  assign fsm_out_0  = disp[0];
  assign fsm_out_1  = disp[1];
  assign fsm_out_2  = disp[2];
  assign fsm_out_3  = disp[3];

endmodule

// File: tb/tb_password_programmer.sv
// Directed bench for password_programmer with a scoreboard queue of
// expected values. Follows PASSWORD_CONFIRM_EN to pick the sequences.
module tb_password_programmer;

  logic        clk = 1'b0;
  logic        rst;
  logic        next;
  logic [3:0]  digit_in;
  logic [15:0] pwd_out;
  logic        pwd_update;
  logic        busy;
  logic [0:6]  fsm_out_0, fsm_out_1, fsm_out_2, fsm_out_3;

  localparam logic [27:0] BLANK4 = {4{7'b1111111}};
  localparam logic [27:0] DONE_D = {7'b1000010, 7'b1100010, 7'b1101010, 7'b0110000};
  localparam logic [27:0] ERR_D  = {7'b1111111, 7'b0110000, 7'b1111010, 7'b1111010};
  localparam logic [6:0]  SEG_C  = 7'b0110001;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic [15:0] cur_pwd;

  password_programmer #(.DEFAULT_PWD(16'h4321)) dut (
    .clk        (clk),
    .rst        (rst),
    .next       (next),
    .digit_in   (digit_in),
    .pwd_out    (pwd_out),
    .pwd_update (pwd_update),
    .busy       (busy),
    .fsm_out_0  (fsm_out_0),
    .fsm_out_1  (fsm_out_1),
    .fsm_out_2  (fsm_out_2),
    .fsm_out_3  (fsm_out_3)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb_q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_state(input string tag, input logic [15:0] pwd, input logic upd,
                              input logic bsy, input logic [27:0] disp);
    sb_push({tag, ".pwd_out"}, {16'h0, pwd});
    sb_push({tag, ".pwd_update"}, {31'h0, upd});
    sb_push({tag, ".busy"}, {31'h0, bsy});
    sb_push({tag, ".display"}, {4'h0, disp});
    sb_check({16'h0, pwd_out});
    sb_check({31'h0, pwd_update});
    sb_check({31'h0, busy});
    sb_check({4'h0, fsm_out_3, fsm_out_2, fsm_out_1, fsm_out_0});
  endtask

  task automatic expect_busy(input string tag, input logic bsy);
    sb_push({tag, ".busy"}, {31'h0, bsy});
    sb_check({31'h0, busy});
  endtask

  task automatic press(input logic [3:0] d);
    digit_in = d;
    next     = 1'b1;
    @(posedge clk); #1;
    $display("press digit=%h busy=%0b pwd_out=%h pwd_update=%0b", d, busy, pwd_out, pwd_update);
  endtask

  task automatic lift();
    next = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic press_lift(input logic [3:0] d);
    press(d);
    lift();
  endtask

  initial begin
    rst      = 1'b1;
    next     = 1'b0;
    digit_in = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    expect_state("in_reset", 16'h4321, 1'b0, 1'b0, BLANK4);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_state("after_reset", 16'h4321, 1'b0, 1'b0, BLANK4);

`ifdef PASSWORD_CONFIRM_EN
    // Mismatch during confirmation
    press_lift(4'd5);
    expect_busy("entry1", 1'b1);
    press_lift(4'd6);
    press_lift(4'd7);
    press_lift(4'd8);
    expect_busy("confirm0", 1'b1);
    sb_push("confirm0.fsm_out_3", {25'h0, SEG_C});
    sb_check({25'h0, fsm_out_3});
    press_lift(4'd5);
    press(4'd9);
    expect_state("confirm_mismatch", 16'h4321, 1'b0, 1'b0, ERR_D);
    lift();
    press_lift(4'd0);
    expect_state("err_to_idle", 16'h4321, 1'b0, 1'b0, BLANK4);

    // Matching confirmation commits
    press_lift(4'd5);
    press_lift(4'd6);
    press_lift(4'd7);
    press_lift(4'd8);
    press_lift(4'd5);
    press_lift(4'd6);
    digit_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    expect_busy("hold_without_press", 1'b1);
    press_lift(4'd7);
    press(4'd8);
    expect_state("commit", 16'h8765, 1'b1, 1'b0, DONE_D);
    lift();
    expect_state("done_hold", 16'h8765, 1'b0, 1'b0, DONE_D);
    press_lift(4'd3);
    expect_state("done_to_idle", 16'h8765, 1'b0, 1'b0, BLANK4);
    cur_pwd = 16'h8765;
`else
    press_lift(4'd9);
    expect_busy("entry1", 1'b1);
    press_lift(4'd0);
    press_lift(4'd1);
    digit_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    expect_busy("hold_without_press", 1'b1);
    press(4'd2);
    expect_state("commit", 16'h2109, 1'b1, 1'b0, DONE_D);
    lift();
    expect_state("done_hold", 16'h2109, 1'b0, 1'b0, DONE_D);
    press_lift(4'd3);
    expect_state("done_to_idle", 16'h2109, 1'b0, 1'b0, BLANK4);
    cur_pwd = 16'h2109;
`endif

    // Invalid digit on the first press, then a long hold counts once
    press(4'hB);
    expect_state("bad_digit", cur_pwd, 1'b0, 1'b0, ERR_D);
    lift();
    digit_in = 4'd3;
    next     = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    expect_state("held_next_once", cur_pwd, 1'b0, 1'b0, BLANK4);
    lift();

    // Reset mid-sequence, then a fresh sequence
    press_lift(4'd1);
    press_lift(4'd2);
    press_lift(4'd3);
    expect_busy("before_mid_reset", 1'b1);
    #3 rst = 1'b1;
    #1;
    expect_state("mid_reset", 16'h4321, 1'b0, 1'b0, BLANK4);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    press_lift(4'd4);
    press_lift(4'd3);
    press_lift(4'd2);
`ifdef PASSWORD_CONFIRM_EN
    press_lift(4'd1);
    press_lift(4'd4);
    press_lift(4'd3);
    press_lift(4'd2);
`endif
    press(4'd1);
    expect_state("fresh_commit", 16'h1234, 1'b1, 1'b0, DONE_D);
    lift();
    press_lift(4'd0);
    expect_state("fresh_idle", 16'h1234, 1'b0, 1'b0, BLANK4);

    // next held high through reset release gives an event on the first clock
    digit_in = 4'd7;
    next     = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    expect_busy("next_through_reset", 1'b1);
    lift();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/password_programmer.md
PASSWORD_PROGRAMMER -- requirements
Module: password_programmer

Interface
REQ-001 Parameter: DEFAULT_PWD, 16'h4321, stored password loaded at reset; nibble [3:0] = first digit, [15:12] = fourth digit.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 next  input  1  level from the entry push-button; each rising edge is one digit-entry event.
REQ-005 digit_in  input  4  BCD digit presented with next.
REQ-006 pwd_out  output  16  committed password, same nibble order as DEFAULT_PWD, read by the checker block.
REQ-007 pwd_update  output  1  one-cycle pulse on the cycle after pwd_out takes a new value.
REQ-008 busy  output  1  high while a programming sequence is in progress (any ENTRY or CONFIRM state).
REQ-009 fsm_out_0..fsm_out_3  output  7 each, [0:6]  active-low seven-segment digits; index 0 = seg a ... 6 = seg g; fsm_out_3 leftmost.

Function
REQ-010 Edge detect: a registered copy of next is kept; next_pulse = next AND NOT registered copy; exactly one event per rising edge of next, regardless of hold time.
REQ-011 States: IDLE, ENTRY (index 0-3), CONFIRM (index 0-3), DONE, ERR.
REQ-012 IDLE: on next_pulse, the block captures digit_in into staging slot 0 and enters ENTRY index 1; busy rises on that same edge.
REQ-013 ENTRY index k (1-3): on next_pulse, the block captures digit_in into staging slot k; index 3 completes the entry and moves to CONFIRM index 0 (or DONE, see REQ-023).
REQ-014 CONFIRM index k (0-3): on next_pulse, the block compares digit_in with staging slot k; a mismatch moves to ERR immediately; a match at k=3 moves to DONE.
REQ-015 A digit_in value of 4'hA-4'hF on any next_pulse in IDLE, ENTRY or CONFIRM moves to ERR; nothing is captured.
REQ-016 Commit: pwd_out is loaded from the staging slots on the same edge that enters DONE; pwd_update is high for exactly the following cycle.
REQ-017 ERR never alters pwd_out; the staging registers are cleared on entry to ERR.
REQ-018 DONE and ERR: next_pulse returns to IDLE and clears the staging registers; no digit is captured on that event.
REQ-019 Without next_pulse, every state holds; digit_in is ignored.
REQ-020 Display:
  - IDLE: all four digits blank (7'b1111111).
  - ENTRY: each digit entered so far shows as a dash (seg g only); the remaining digits are blank.
  - CONFIRM: the same rule applies, with fsm_out_3 showing "C".
  - DONE: "donE".
  - ERR: blank, "E", "r", "r".
  - The display decode is combinational from the state and index.

Reset
REQ-021 Asserting rst at any time, including mid-sequence:
  - state returns to IDLE.
  - staging registers clear to 0.
  - pwd_out loads DEFAULT_PWD.
  - pwd_update and busy go to 0.
  - the registered copy of next clears to 0.
  - the display shows blank.
REQ-022 If next is held high through reset release, a rising edge is recognised on the first clock after release.

Configuration
REQ-023 Macro PASSWORD_CONFIRM_EN:
  - When defined, the CONFIRM phase of REQ-014 is compiled in.
  - When undefined, there is no CONFIRM state: the ENTRY index 3 event commits and enters DONE directly (REQ-016 still applies), and ERR is reachable only through REQ-015.

Verification
REQ-024 Reset, then sample -> pwd_out=16'h4321, pwd_update=0, busy=0, all displays blank.
REQ-025 (CONFIRM_EN) Digits 5,6,7,8 then 5,6,7,8 -> DONE, pwd_out=16'h8765, one-cycle pwd_update, display "donE".
REQ-026 (CONFIRM_EN) Digits 5,6,7,8 then 5,9 -> ERR after the 6th press, pwd_out stays 16'h4321, display " Err"; the next press -> IDLE.
REQ-027 Digit 4'hB on the first press -> ERR with no capture; next held high for 20 cycles -> only one event is counted.
REQ-028 Assert rst after the 3rd ENTRY digit -> IDLE, pwd_out=DEFAULT_PWD; a fresh sequence then completes normally.
REQ-029 (no CONFIRM_EN) Digits 9,0,1,2 -> DONE on the 4th press, pwd_out=16'h2109.
